// File: rtl/wdt_pkg.sv
// Shared state encodings and default parameters for the watchdog service generator.
// No logic here; latency and backpressure are not applicable.
package wdt_pkg;

   typedef logic [1:0] wdt_state_t;

   localparam wdt_state_t ST_IDLE  = 2'd0;
   localparam wdt_state_t ST_ARMED = 2'd1;
   localparam wdt_state_t ST_KICK  = 2'd2;
   localparam wdt_state_t ST_FAULT = 2'd3;

   localparam int DEF_CNT_WIDTH   = 5;
   localparam int DEF_KICK_PERIOD = 8;
   localparam int DEF_MAX_MISSES  = 2;

endpackage

// File: rtl/wdt_period_ctr.sv
// Service-period counter: wraps at KICK_PERIOD-1 and flags the last cycle of each period.
// Expiry is combinational from the count register; no backpressure, clear wins over enable.
module wdt_period_ctr
   import wdt_pkg::*;
#(
   parameter int KICK_PERIOD = DEF_KICK_PERIOD
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_en,
   input  logic i_clr,
   output logic o_expiry
);

   localparam logic [7:0] LAST = 8'(KICK_PERIOD - 1);

   logic [7:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= (r_cnt == LAST) ? 8'd0 : r_cnt + 8'd1;
      end
   end

   assign o_expiry = (r_cnt == LAST);

endmodule

// File: rtl/wdt_service_gen.sv
// Watchdog service generator: one-cycle registered kick every KICK_PERIOD cycles while heartbeats arrive.
// First kick KICK_PERIOD+1 cycles after enable; no backpressure, missed heartbeats or timeout latch FAULT.
module wdt_service_gen
   import wdt_pkg::*;
#(
   parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
   parameter int KICK_PERIOD = DEF_KICK_PERIOD,
   parameter int MAX_MISSES  = DEF_MAX_MISSES
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 heartbeat,
   input  logic                 wdt_timeout,
   input  logic                 fault_clr,
   output logic                 service,
   output logic [CNT_WIDTH-1:0] kick_cnt,
   output logic [2:0]           miss_cnt,
   output logic                 fault,
   output logic [1:0]           state
);

   localparam logic [2:0]           MISS_LIMIT = 3'(MAX_MISSES);
   localparam logic [CNT_WIDTH-1:0] KICK_SAT   = '1;
   localparam logic [CNT_WIDTH-1:0] KICK_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   wdt_state_t           r_state;
   wdt_state_t           w_state_nxt;
   logic                 r_service;
   logic                 r_hb_seen;
   logic                 w_hb_nxt;
   logic [2:0]           r_miss_cnt;
   logic [2:0]           w_miss_nxt;
   logic [2:0]           w_miss_inc;
   logic [CNT_WIDTH-1:0] r_kick_cnt;
   logic                 w_expiry;
   logic                 w_active;
   logic                 w_per_clr;

   assign w_active   = (r_state == ST_ARMED) || (r_state == ST_KICK);
   // Leaving ARMED/KICK (to IDLE or FAULT) restarts the period from zero.
   assign w_per_clr  = !w_active || wdt_timeout || !en;
   assign w_miss_inc = r_miss_cnt + 3'd1;

   wdt_period_ctr #(
      .KICK_PERIOD (KICK_PERIOD)
   ) u_period_ctr (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_en     (w_active),
      .i_clr    (w_per_clr),
      .o_expiry (w_expiry)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_hb_nxt    = r_hb_seen;
      w_miss_nxt  = r_miss_cnt;
      case (r_state)
         ST_IDLE: begin
            w_hb_nxt   = 1'b0;
            w_miss_nxt = 3'd0;
            if (en) w_state_nxt = ST_ARMED;
         end
         ST_ARMED: begin
            if (wdt_timeout) begin
               w_state_nxt = ST_FAULT;
               w_hb_nxt    = 1'b0;
            end else if (!en) begin
               w_state_nxt = ST_IDLE;
               w_hb_nxt    = 1'b0;
               w_miss_nxt  = 3'd0;
            end else if (w_expiry) begin
               w_hb_nxt = 1'b0;
               if (r_hb_seen || heartbeat) begin
                  w_state_nxt = ST_KICK;
                  w_miss_nxt  = 3'd0;
               end else begin
                  w_miss_nxt = w_miss_inc;
                  if (w_miss_inc == MISS_LIMIT) w_state_nxt = ST_FAULT;
               end
            end else if (heartbeat) begin
               w_hb_nxt = 1'b1;
            end
         end
         ST_KICK: begin
            if (wdt_timeout) begin
               w_state_nxt = ST_FAULT;
               w_hb_nxt    = 1'b0;
            end else if (!en) begin
               w_state_nxt = ST_IDLE;
               w_hb_nxt    = 1'b0;
               w_miss_nxt  = 3'd0;
            end else begin
               w_state_nxt = ST_ARMED;
               if (heartbeat) w_hb_nxt = 1'b1;
            end
         end
         default: begin
            w_hb_nxt = 1'b0;
            if (fault_clr && !wdt_timeout) begin
               w_state_nxt = ST_IDLE;
               w_miss_nxt  = 3'd0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_service  <= 1'b0;
         r_hb_seen  <= 1'b0;
         r_miss_cnt <= 3'd0;
         r_kick_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_service  <= (w_state_nxt == ST_KICK);
         r_hb_seen  <= w_hb_nxt;
         r_miss_cnt <= w_miss_nxt;
         if ((w_state_nxt == ST_KICK) && (r_kick_cnt != KICK_SAT)) begin
            r_kick_cnt <= r_kick_cnt + KICK_ONE;
         end
      end
   end

   assign service  = r_service;
   assign kick_cnt = r_kick_cnt;
   assign miss_cnt = r_miss_cnt;
   assign fault    = (r_state == ST_FAULT);
   assign state    = r_state;

endmodule

// File: tb/tb_wdt_service_gen.sv
// Directed bench for wdt_service_gen: vector table for the main sequence, hand sequences for
// saturation and reset during a kick.
module tb_wdt_service_gen;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       heartbeat;
   logic       wdt_timeout;
   logic       fault_clr;
   logic       service;
   logic [4:0] kick_cnt;
   logic [2:0] miss_cnt;
   logic       fault;
   logic [1:0] state;

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct {
      int         n;
      logic       en;
      logic       hb;
      logic       to;
      logic       clr;
      logic [1:0] st;
      logic       svc;
      logic       flt;
      logic [2:0] miss;
      logic [4:0] kick;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   wdt_service_gen #(
      .CNT_WIDTH   (5),
      .KICK_PERIOD (8),
      .MAX_MISSES  (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .heartbeat   (heartbeat),
      .wdt_timeout (wdt_timeout),
      .fault_clr   (fault_clr),
      .service     (service),
      .kick_cnt    (kick_cnt),
      .miss_cnt    (miss_cnt),
      .fault       (fault),
      .state       (state)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic vec_t v(input int n, input logic e, input logic h, input logic t,
                              input logic c, input logic [1:0] st, input logic sv,
                              input logic f, input logic [2:0] m, input logic [4:0] k);
      vec_t r;
      r.n = n; r.en = e; r.hb = h; r.to = t; r.clr = c;
      r.st = st; r.svc = sv; r.flt = f; r.miss = m; r.kick = k;
      return r;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      int pulses;
      int last;
      int bad_gap;

      // Cycle numbers in the comments count from the cycle in which en is first driven high.
      vecs.push_back(v(1,  1, 0, 0, 0, 2'd1, 0, 0, 3'd0, 5'd0));  // c1  ARMED
      vecs.push_back(v(2,  1, 0, 0, 0, 2'd1, 0, 0, 3'd0, 5'd0));  // c3
      vecs.push_back(v(1,  1, 1, 0, 0, 2'd1, 0, 0, 3'd0, 5'd0));  // c4  heartbeat in c3
      vecs.push_back(v(5,  1, 0, 0, 0, 2'd2, 1, 0, 3'd0, 5'd1));  // c9  first kick
      vecs.push_back(v(1,  1, 1, 0, 0, 2'd1, 0, 0, 3'd0, 5'd1));  // c10 heartbeat during KICK
      vecs.push_back(v(7,  1, 0, 0, 0, 2'd2, 1, 0, 3'd0, 5'd2));  // c17 second kick
      vecs.push_back(v(7,  1, 0, 0, 0, 2'd1, 0, 0, 3'd0, 5'd2));  // c24 expiry cycle
      vecs.push_back(v(1,  1, 1, 0, 0, 2'd2, 1, 0, 3'd0, 5'd3));  // c25 heartbeat at expiry
      vecs.push_back(v(1,  1, 0, 0, 0, 2'd1, 0, 0, 3'd0, 5'd3));  // c26
      vecs.push_back(v(6,  1, 0, 0, 0, 2'd1, 0, 0, 3'd0, 5'd3));  // c32 expiry, no heartbeat
      vecs.push_back(v(1,  1, 0, 0, 0, 2'd1, 0, 0, 3'd1, 5'd3));  // c33 first miss
      vecs.push_back(v(7,  1, 0, 0, 0, 2'd1, 0, 0, 3'd1, 5'd3));  // c40
      vecs.push_back(v(1,  1, 0, 0, 0, 2'd3, 0, 1, 3'd2, 5'd3));  // c41 second miss -> FAULT
      vecs.push_back(v(10, 1, 1, 0, 0, 2'd3, 0, 1, 3'd2, 5'd3));  // en/heartbeat ignored
      vecs.push_back(v(1,  1, 0, 1, 1, 2'd3, 0, 1, 3'd2, 5'd3));  // clear with timeout stays
      vecs.push_back(v(1,  0, 0, 0, 1, 2'd0, 0, 0, 3'd0, 5'd3));  // clear -> IDLE
      vecs.push_back(v(2,  0, 0, 0, 1, 2'd0, 0, 0, 3'd0, 5'd3));  // clear ignored in IDLE
      vecs.push_back(v(1,  1, 0, 0, 0, 2'd1, 0, 0, 3'd0, 5'd3));  // ARMED
      vecs.push_back(v(1,  0, 0, 0, 0, 2'd0, 0, 0, 3'd0, 5'd3));  // en=0 -> IDLE, kicks kept
      vecs.push_back(v(1,  1, 0, 0, 0, 2'd1, 0, 0, 3'd0, 5'd3));  // c1 ARMED again
      vecs.push_back(v(7,  1, 0, 0, 0, 2'd1, 0, 0, 3'd0, 5'd3));  // c8 expiry cycle
      vecs.push_back(v(1,  1, 1, 1, 0, 2'd3, 0, 1, 3'd0, 5'd3));  // timeout beats the kick
      vecs.push_back(v(1,  1, 0, 0, 1, 2'd0, 0, 0, 3'd0, 5'd3));  // clear -> IDLE
      vecs.push_back(v(1,  1, 1, 0, 0, 2'd1, 0, 0, 3'd0, 5'd3));  // ARMED next cycle

      rst_n       = 1'b0;
      en          = 1'b0;
      heartbeat   = 1'b0;
      wdt_timeout = 1'b0;
      fault_clr   = 1'b0;
      step(2);
      chk("reset.state",   int'(state),    0);
      chk("reset.service", int'(service),  0);
      chk("reset.fault",   int'(fault),    0);
      chk("reset.kick",    int'(kick_cnt), 0);
      chk("reset.miss",    int'(miss_cnt), 0);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         en          = vecs[i].en;
         heartbeat   = vecs[i].hb;
         wdt_timeout = vecs[i].to;
         fault_clr   = vecs[i].clr;
         step(vecs[i].n);
         chk($sformatf("row%0d.state", i),   int'(state),    int'(vecs[i].st));
         chk($sformatf("row%0d.service", i), int'(service),  int'(vecs[i].svc));
         chk($sformatf("row%0d.fault", i),   int'(fault),    int'(vecs[i].flt));
         chk($sformatf("row%0d.miss", i),    int'(miss_cnt), int'(vecs[i].miss));
         chk($sformatf("row%0d.kick", i),    int'(kick_cnt), int'(vecs[i].kick));
      end

      // Saturation: heartbeat held high, count 40 kicks and their spacing.
      en          = 1'b1;
      heartbeat   = 1'b1;
      wdt_timeout = 1'b0;
      fault_clr   = 1'b0;
      pulses  = 0;
      last    = 0;
      bad_gap = 0;
      for (int i = 0; i < 400 && pulses < 40; i++) begin
         step(1);
         if (service) begin
            if (pulses > 0 && (i - last) != 8) bad_gap++;
            last = i;
            pulses++;
         end
      end
      chk("sat.pulses",  pulses,        40);
      chk("sat.gaps",    bad_gap,       0);
      chk("sat.kick",    int'(kick_cnt), 31);
      chk("sat.in_kick", int'(state),    2);

      // Reset asserted while the kick is on the output.
      rst_n = 1'b0;
      #1;
      chk("rstkick.service", int'(service),  0);
      chk("rstkick.state",   int'(state),    0);
      chk("rstkick.kick",    int'(kick_cnt), 0);
      #2;
      rst_n = 1'b1;
      step(1);
      chk("resume.state", int'(state), 1);
      step(8);
      chk("resume.service", int'(service),  1);
      chk("resume.kick",    int'(kick_cnt), 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
